// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data-memory access unit.
// Holds the access-size encoding, the FSM state enum and the lane-mask constants.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

    // Bit offset of the addressed lane inside a little-endian 32-bit word.
    function automatic logic [4:0] lane_shift(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_shift = {off, 3'b000};
            SIZE_HALF: lane_shift = {off[1], 4'b0000};
            default:   lane_shift = 5'd0;
        endcase
    endfunction

    // Right-aligned mask covering one lane of the given size.
    function automatic logic [31:0] lane_mask(input size_e size);
        case (size)
            SIZE_BYTE: lane_mask = LANE_MASK_BYTE;
            SIZE_HALF: lane_mask = LANE_MASK_HALF;
            default:   lane_mask = LANE_MASK_WORD;
        endcase
    endfunction

    // Without sub-word support every non-word size is reported as an error.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off,
                                           input logic subword_en);
        case (size)
            SIZE_BYTE: is_misaligned = !subword_en;
            SIZE_HALF: is_misaligned = !subword_en || off[0];
            SIZE_WORD: is_misaligned = (off != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational lane handling.
// Load side extracts and extends a byte/half from a RAM word; store side
// replaces one lane of a previously read word with new data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] ld_word,
    input  size_e       ld_size,
    input  logic        ld_signed,
    input  logic [1:0]  ld_off,
    output logic [31:0] ld_data,
    input  logic [31:0] st_word,
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] st_mask;
    logic [4:0]  st_shift;

    // Pick the addressed lane and zero- or sign-extend it to 32 bits.
    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default:   ld_data = ld_word;
        endcase
    end

    // Keep the untouched lanes of the old word and drop the new data into the target lane.
    always_comb begin
        st_shift  = lane_shift(st_size, st_off);
        st_mask   = lane_mask(st_size) << st_shift;
        st_merged = (st_word & ~st_mask) | ((st_wdata << st_shift) & st_mask);
    end

endmodule

// File: rtl/dmem_access.sv
// dmem_access: load/store unit between a request port and a single-port RAM.
// Sub-word stores use a read-modify-write through the MERGE state.
// Build option: define DMEM_SUBWORD_EN to enable byte and half accesses;
// without it only aligned word accesses succeed and MERGE is never entered.
module dmem_access
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] daddr,
    output logic              mwe,
    output logic [31:0]       res,
    input  logic [31:0]       memdata
);

`ifdef DMEM_SUBWORD_EN
    localparam logic SUBWORD_EN = 1'b1;
`else
    localparam logic SUBWORD_EN = 1'b0;
`endif

    state_e            state, state_n;
    logic [ADDR_W-1:0] lat_addr;
    size_e             lat_size;
    logic [31:0]       lat_wdata;
    logic [31:0]       lat_word;

    size_e       req_size_e;
    logic        req_err;
    logic        latch_en;
    logic        resp_fire;
    logic        resp_err_n;
    logic [31:0] resp_rdata_n;
    logic        mwe_int;
    logic [31:0] ld_data;
    logic [31:0] st_merged;

    assign req_size_e = size_e'(req_size);

    // RAM writes are suppressed for as long as reset is held.
    assign mwe = mwe_int & rst;

    dmem_lane_align u_lane_align (
        .ld_word   (memdata),
        .ld_size   (req_size_e),
        .ld_signed (req_signed),
        .ld_off    (req_addr[1:0]),
        .ld_data   (ld_data),
        .st_word   (lat_word),
        .st_size   (lat_size),
        .st_off    (lat_addr[1:0]),
        .st_wdata  (lat_wdata),
        .st_merged (st_merged)
    );

    // Next state, RAM controls and the response to register at the next edge.
    always_comb begin
        state_n      = state;
        req_ready    = 1'b0;
        daddr        = req_addr;
        mwe_int      = 1'b0;
        res          = req_wdata;
        latch_en     = 1'b0;
        resp_fire    = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = 32'h0;
        req_err      = is_misaligned(req_size_e, req_addr[1:0], SUBWORD_EN);
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        resp_fire  = 1'b1;
                        resp_err_n = 1'b1;
                    end else if (!req_we) begin
                        resp_fire    = 1'b1;
                        resp_rdata_n = ld_data;
                    end else if (req_size_e == SIZE_WORD) begin
                        mwe_int   = 1'b1;
                        resp_fire = 1'b1;
                    end
`ifdef DMEM_SUBWORD_EN
                    else begin
                        latch_en = 1'b1;
                        state_n  = MERGE;
                    end
`endif
                end
            end
            MERGE: begin
                daddr     = lat_addr;
                mwe_int   = 1'b1;
                res       = st_merged;
                resp_fire = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, read-modify-write latches and the registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_size   <= SIZE_BYTE;
            lat_wdata  <= 32'h0;
            lat_word   <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            resp_valid <= resp_fire;
            if (resp_fire) begin
                resp_rdata <= resp_rdata_n;
                resp_err   <= resp_err_n;
            end
            if (latch_en) begin
                lat_addr  <= req_addr;
                lat_size  <= req_size_e;
                lat_wdata <= req_wdata;
                lat_word  <= memdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: scoreboard bench for dmem_access with a behavioural RAM.
// Expectations follow DMEM_SUBWORD_EN so the bench suits either build.
module tb_dmem_access;

`ifdef DMEM_SUBWORD_EN
    localparam logic SUB = 1'b1;
`else
    localparam logic SUB = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [24:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [24:0] daddr;
    logic        mwe;
    logic [31:0] res, memdata;

    logic [31:0] mem [0:1023];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    dmem_access #(.ADDR_W(25)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .daddr      (daddr),
        .mwe        (mwe),
        .res        (res),
        .memdata    (memdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, synchronous write.
    assign memdata = mem[daddr[11:2]];
    always @(posedge clk) begin
        if (mwe) mem[daddr[11:2]] <= res;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_resp: got rdata 0x%08h err %0b expected no response",
                         resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                if (e.chk_rdata) checkOutput("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    // Issue one request, queue its expected response and check the accept/merge cycles.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [24:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input logic chk_rdata, input logic exp_mwe, input logic exp_merge);
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata     = exp_rdata;
        e.err       = exp_err;
        e.chk_rdata = chk_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        checkOutput({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_mwe"}, {31'b0, mwe}, {31'b0, exp_mwe});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        if (exp_merge) begin
            @(negedge clk);
            checkOutput({tag, "_merge_ready"}, {31'b0, req_ready}, 32'd0);
            checkOutput({tag, "_merge_mwe"}, {31'b0, mwe}, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'h80F0_7F01;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = '0; req_wdata = 32'h0;

        // Reset held with a live word-store request: nothing may reach the RAM.
        #2 rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 25'h010; req_wdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mwe", {31'b0, mwe}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        checkOutput("rst_no_write", mem[4], 32'h0);

        // Word store then word load of the same address.
        applyStimulus("st_w", 1, 2'b10, 0, 25'h010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 0);
        applyStimulus("ld_w", 0, 2'b10, 0, 25'h010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0);
        checkOutput("ram_010", mem[4], 32'hDEAD_BEEF);

        // Byte store with read-modify-write, then an immediate word load.
        applyStimulus("st_b", 1, 2'b00, 0, 25'h022, 32'h0000_00AA, 32'h0, !SUB, !SUB, 0, SUB);
        checkOutput("ram_020_b", mem[8], SUB ? 32'h11AA_3344 : 32'h1122_3344);
        applyStimulus("ld_w20", 0, 2'b10, 0, 25'h020, 32'h0,
                      SUB ? 32'h11AA_3344 : 32'h1122_3344, 0, 1, 0, 0);

        // Half store into the upper lane, read back.
        applyStimulus("st_h", 1, 2'b01, 0, 25'h022, 32'hFFFF_1234, 32'h0, !SUB, !SUB, 0, SUB);
        applyStimulus("ld_w20h", 0, 2'b10, 0, 25'h020, 32'h0,
                      SUB ? 32'h1234_3344 : 32'h1122_3344, 0, 1, 0, 0);

        // Sub-word loads with both extensions.
        applyStimulus("ld_bs", 0, 2'b00, 1, 25'h032, 32'h0, SUB ? 32'hFFFF_FFF0 : 32'h0, !SUB, 1, 0, 0);
        applyStimulus("ld_hu", 0, 2'b01, 0, 25'h032, 32'h0, SUB ? 32'h0000_80F0 : 32'h0, !SUB, 1, 0, 0);
        applyStimulus("ld_hs", 0, 2'b01, 1, 25'h032, 32'h0, SUB ? 32'hFFFF_80F0 : 32'h0, !SUB, 1, 0, 0);
        applyStimulus("ld_bu", 0, 2'b00, 0, 25'h031, 32'h0, SUB ? 32'h0000_007F : 32'h0, !SUB, 1, 0, 0);
        applyStimulus("ld_hs0", 0, 2'b01, 1, 25'h030, 32'h0, SUB ? 32'h0000_7F01 : 32'h0, !SUB, 1, 0, 0);

        // Misaligned and reserved-size accesses.
        applyStimulus("mis_ldw", 0, 2'b10, 0, 25'h005, 32'h0, 32'h0, 1, 1, 0, 0);
        applyStimulus("mis_sth", 1, 2'b01, 0, 25'h031, 32'h0000_5555, 32'h0, 1, 1, 0, 0);
        checkOutput("ram_030", mem[12], 32'h80F0_7F01);
        applyStimulus("rsv_st", 1, 2'b11, 0, 25'h024, 32'hCAFE_F00D, 32'h0, 1, 1, 0, 0);
        checkOutput("ram_024", mem[9], 32'h0);
        applyStimulus("rsv_ld", 0, 2'b11, 0, 25'h010, 32'h0, 32'h0, 1, 1, 0, 0);

`ifdef DMEM_SUBWORD_EN
        // Reset in MERGE drops the pending write and its response.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 25'h010; req_wdata = 32'hCC;
        @(negedge clk);
        checkOutput("rm_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; rst = 1'b0;
        @(negedge clk);
        checkOutput("rm_mwe", {31'b0, mwe}, 32'd0);
        checkOutput("rm_resp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rm_idle", {31'b0, req_ready}, 32'd1);
        checkOutput("rm_noresp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
`else
        applyStimulus("nosub_ldb", 0, 2'b00, 0, 25'h010, 32'h0, 32'h0, 1, 1, 0, 0);
`endif
        checkOutput("ram_010_kept", mem[4], 32'hDEAD_BEEF);
        applyStimulus("ld_final", 0, 2'b10, 0, 25'h010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0);

        // Give outstanding responses a bounded time to arrive.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
